alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
Execute-to-writeback stage directly downstream of the shift/ALU execute unit. Captures each execute result (data, destination register, write enable) through a valid/ready handshake into a 2-entry skid buffer. Drains the buffer in order to the register-file write port, which may stall. Exposes a forwarding port so the execute stage can bypass results not yet written.

Parameters:
DATA_WIDTH, 32 (from simple_processor_pkg), result and register data width
REG_ADDR_WIDTH, 5, register index width; register 0 is hardwired zero
DEPTH, 2, skid buffer entries; fixed at 2, elaboration error otherwise

Ports:
clk_i  input  1  single clock, all flops on rising edge
arst_ni  input  1  asynchronous active-low reset
ex_valid_i  input  1  execute result valid
ex_ready_o  output  1  stage can accept a result this cycle
ex_result_i  input  DATA_WIDTH  execute result (e.g. shifter output)
ex_rd_addr_i  input  REG_ADDR_WIDTH  destination register
ex_rd_we_i  input  1  instruction writes rd
flush_i  input  1  discard all buffered and incoming results
rf_wr_en_o  output  1  register-file write request
rf_wr_ready_i  input  1  register file accepts the write this cycle
rf_wr_addr_o  output  REG_ADDR_WIDTH  write address
rf_wr_data_o  output  DATA_WIDTH  write data
fwd_valid_o  output  1  forwarding data valid
fwd_addr_o  output  REG_ADDR_WIDTH  forwarded register
fwd_data_o  output  DATA_WIDTH  forwarded value (youngest buffered entry)
busy_o  output  1  buffer non-empty

Behaviour:
- States: EMPTY, ONE, FULL (entry count 0/1/2). Head and tail pointers are 1 bit and wrap modulo 2.
- Accept = ex_valid_i & ex_ready_o & !flush_i. ex_ready_o = (state != FULL), registered-state derived with no combinational path from ex_valid_i.
- On accept, entries with ex_rd_we_i=0 or ex_rd_addr_i=0 are consumed and discarded; count is unchanged.
- Drain = rf_wr_en_o & rf_wr_ready_i. rf_wr_en_o = (state != EMPTY) & !flush_i. Addr and data come from the head entry.
- Latency: a result accepted at edge N drives rf_wr_en_o in cycle N+1 at the earliest. Throughput is 1 per cycle while rf_wr_ready_i=1.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + drain -> ONE (head advances, new tail written).
  - ONE + accept only -> FULL.
  - ONE + drain only -> EMPTY.
  - FULL + drain -> ONE. FULL never accepts.
- rf_wr_ready_i=0 holds head addr and data stable until drained.
- flush_i: next state EMPTY and pointers cleared. Same-cycle accept is ignored and same-cycle write is suppressed. Flush has priority over everything.
- Forwarding:
  - fwd_valid_o = (state != EMPTY).
  - fwd_addr_o and fwd_data_o come from the youngest entry (tail-1).
  - When both entries hold the same rd, the younger wins.
  - Outputs are 0 when not valid.
- Reset (arst_ni low, asynchronous): state EMPTY, pointers 0, entry storage 0.
  - rf_wr_en_o, fwd_valid_o, busy_o = 0; rf_wr_addr_o, rf_wr_data_o, fwd_addr_o, fwd_data_o = 0; ex_ready_o = 1.
  - Reset mid-operation drops buffered entries with no write issued.
- Data is passed through unmodified; no width conversion.

Optional Feature:
WB_PERF_CNT_EN:
- Defined: adds outputs perf_wr_cnt_o (32 bit, increments on each drain) and perf_stall_cnt_o (32 bit, increments each cycle rf_wr_en_o=1 & rf_wr_ready_i=0).
- Both counters saturate at all-ones, reset to 0 asynchronously, and are unaffected by flush_i.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- simple_processor_pkg gains:
  - REG_ADDR_WIDTH constant.
  - wb_entry_t packed struct {data [DATA_WIDTH], rd [REG_ADDR_WIDTH]}.
  - wb_state_e enum {EMPTY, ONE, FULL}.
- One natural sub-module: wb_skid_fifo, a 2-entry wb_entry_t storage with push/pop/flush, count and youngest-entry read. alu_wb_stage adds filtering, the handshake, forwarding and the optional counters.

Test Plan:
- Reset then single result 0xDEADBEEF rd=5 we=1, rf_wr_ready_i=1 -> rf_wr_en_o high exactly one cycle later with addr 5 and data 0xDEADBEEF; busy_o returns 0 the cycle after.
- Back-to-back results rd=1..4, rf_wr_ready_i=1 -> four writes on consecutive cycles in order; ex_ready_o stays 1 throughout.
- rf_wr_ready_i=0, push rd=3 0x11 then rd=3 0x22 -> state FULL, ex_ready_o=0, fwd_data_o=0x22; release ready -> writes 0x11 then 0x22.
- Push rd=0 data 0xFFFF_FFFF and rd=7 we=0 -> both accepted, no rf_wr_en_o ever asserted, fwd_valid_o stays 0.
- FULL buffer, flush_i asserted together with ex_valid_i -> no write that cycle, EMPTY next cycle, incoming result lost; arst_ni pulsed while FULL -> same empty outcome, no write.
- With WB_PERF_CNT_EN, 3 stall cycles then 2 writes -> perf_stall_cnt_o=3, perf_wr_cnt_o=2.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// ============================================================================
// Module      : simple_processor_pkg
// Description : Shared widths, writeback entry type and skid-buffer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_processor_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_wb_stage_if.sv
// ============================================================================
// Module      : alu_wb_stage_if
// Description : Execute handshake, register-file write and forwarding bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_wb_stage_if;
  import simple_processor_pkg::*;

  logic                      ex_valid_i;
  logic                      ex_ready_o;
  logic [DATA_WIDTH-1:0]     ex_result_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i;
  logic                      ex_rd_we_i;
  logic                      flush_i;
  logic                      rf_wr_en_o;
  logic                      rf_wr_ready_i;
  logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_o;
  logic [DATA_WIDTH-1:0]     rf_wr_data_o;
  logic                      fwd_valid_o;
  logic [REG_ADDR_WIDTH-1:0] fwd_addr_o;
  logic [DATA_WIDTH-1:0]     fwd_data_o;
  logic                      busy_o;

  // Execute unit and register file side
  modport master (
    output ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i, flush_i, rf_wr_ready_i,
    input  ex_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
    input  fwd_valid_o, fwd_addr_o, fwd_data_o, busy_o
  );

  // Writeback stage side
  modport slave (
    input  ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i, flush_i, rf_wr_ready_i,
    output ex_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
    output fwd_valid_o, fwd_addr_o, fwd_data_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/alu_wb_stage_skid_fifo.sv
// ============================================================================
// Module      : wb_skid_fifo
// Description : Two-entry in-order writeback buffer with push/pop/flush,
//               occupancy state, head read and youngest-entry read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_skid_fifo
  import simple_processor_pkg::*;
(
  input  wire        clk_i,
  input  wire        arst_ni,
  input  wire        push_i,
  input  wb_entry_t  push_entry_i,
  input  wire        pop_i,
  input  wire        flush_i,
  output wb_state_e  state_o,
  output wb_entry_t  head_o,
  output wb_entry_t  youngest_o
);

  wb_state_e state_q, state_d;
  logic      wr_ptr_q, wr_ptr_d;
  logic      rd_ptr_q, rd_ptr_d;
  wb_entry_t mem_q [2];
  wb_entry_t mem_d [2];
  logic      do_push, do_pop;

  assign do_push = push_i && (state_q != FULL);
  assign do_pop  = pop_i  && (state_q != EMPTY);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush_i) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case (state_q)
        EMPTY:   if (do_push) state_d = ONE;
        ONE: begin
          if (do_push && !do_pop)      state_d = FULL;
          else if (do_pop && !do_push) state_d = EMPTY;
        end
        FULL:    if (do_pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign state_o    = state_q;
  assign head_o     = mem_q[rd_ptr_q];
  // Youngest entry sits one slot behind the write pointer
  assign youngest_o = mem_q[~wr_ptr_q];

endmodule

`default_nettype wire

// File: rtl/alu_wb_stage.sv
// ============================================================================
// Module      : alu_wb_stage
// Description : Execute-to-writeback stage: filters execute results, buffers
//               them in a 2-entry skid FIFO, drains to the register file and
//               forwards the youngest buffered result.
//               Optional macro WB_PERF_CNT_EN adds write/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_wb_stage #(
  parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = simple_processor_pkg::REG_ADDR_WIDTH,
  parameter int DEPTH          = 2
) (
  input  wire                 clk_i,
  input  wire                 arst_ni,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]         perf_wr_cnt_o,
  output logic [31:0]         perf_stall_cnt_o,
`endif
  alu_wb_stage_if.slave       bus
);
  import simple_processor_pkg::*;

  generate
    if (DEPTH != 2 || DATA_WIDTH != simple_processor_pkg::DATA_WIDTH ||
        REG_ADDR_WIDTH != simple_processor_pkg::REG_ADDR_WIDTH) begin : g_param_check
      $error("alu_wb_stage: DEPTH must be 2 and widths must match simple_processor_pkg");
    end
  endgenerate

  wb_state_e state;
  wb_entry_t head, youngest, push_entry;
  logic      accept, push, pop, not_empty;

  assign not_empty       = (state != EMPTY);
  assign bus.ex_ready_o  = (state != FULL);
  assign accept          = bus.ex_valid_i && bus.ex_ready_o && !bus.flush_i;
  // Results that never reach the register file are consumed here
  assign push            = accept && bus.ex_rd_we_i && (bus.ex_rd_addr_i != '0);
  assign bus.rf_wr_en_o  = not_empty && !bus.flush_i;
  assign pop             = bus.rf_wr_en_o && bus.rf_wr_ready_i;

  assign push_entry.data = bus.ex_result_i;
  assign push_entry.rd   = bus.ex_rd_addr_i;

  wb_skid_fifo u_fifo (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.flush_i),
    .state_o      (state),
    .head_o       (head),
    .youngest_o   (youngest)
  );

  assign bus.rf_wr_addr_o = not_empty ? head.rd   : '0;
  assign bus.rf_wr_data_o = not_empty ? head.data : '0;
  assign bus.fwd_valid_o  = not_empty;
  assign bus.fwd_addr_o   = not_empty ? youngest.rd   : '0;
  assign bus.fwd_data_o   = not_empty ? youngest.data : '0;
  assign bus.busy_o       = not_empty;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_wr_cnt_d    = perf_wr_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (pop && perf_wr_cnt_q != '1)
      perf_wr_cnt_d = perf_wr_cnt_q + 32'd1;
    if (bus.rf_wr_en_o && !bus.rf_wr_ready_i && perf_stall_cnt_q != '1)
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      perf_wr_cnt_q    <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_wr_cnt_q    <= perf_wr_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_wr_cnt_o    = perf_wr_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
// ============================================================================
// Module      : tb_alu_wb_stage
// Description : Self-checking bench for alu_wb_stage (scoreboard of expected
//               register-file writes). Honours WB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_wb_stage;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  alu_wb_stage_if bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  alu_wb_stage dut (
    .clk_i            (clk),
    .arst_ni          (arst_n),
`ifdef WB_PERF_CNT_EN
    .perf_wr_cnt_o    (perf_wr_cnt),
    .perf_stall_cnt_o (perf_stall_cnt),
`endif
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted write must match the oldest expectation
  always @(negedge clk) begin
    if (arst_n && bus.rf_wr_en_o && bus.rf_wr_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, expected no write",
                 bus.rf_wr_addr_o, bus.rf_wr_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.rf_wr_addr_o !== e.rd || bus.rf_wr_data_o !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.rf_wr_addr_o, bus.rf_wr_data_o, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we);
    bus.ex_valid_i   = v;
    bus.ex_rd_addr_i = rd;
    bus.ex_result_i  = d;
    bus.ex_rd_we_i   = we;
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    cyc();
    cyc();
    arst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    pulse_reset();
    @(negedge clk);
    n_checks += 7;
    if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.ex_ready_o); end
    if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", bus.rf_wr_en_o); end
    if (bus.fwd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_valid: got %b expected 0", bus.fwd_valid_o); end
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
    if (bus.rf_wr_addr_o !== 5'd0 || bus.rf_wr_data_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_wr_bus: got %0d/%h expected 0/0", bus.rf_wr_addr_o, bus.rf_wr_data_o);
    end
    if (bus.fwd_addr_o !== 5'd0) begin n_fail++; $display("FAIL rst_fwd_addr: got %0d expected 0", bus.fwd_addr_o); end
    if (bus.fwd_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_fwd_data: got %h expected 0", bus.fwd_data_o); end
  endtask

  task automatic test_single();
    cyc();
    bus.rf_wr_ready_i = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_checks += 2;
    if (bus.rf_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL single_latency: wr_en got %b expected 1", bus.rf_wr_en_o); end
    if (bus.fwd_valid_o !== 1'b1 || bus.fwd_addr_o !== 5'd5 || bus.fwd_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_fwd: got v=%b %0d/%h expected 1 5/deadbeef",
                         bus.fwd_valid_o, bus.fwd_addr_o, bus.fwd_data_o);
    end
    cyc();
    @(negedge clk);
    n_checks += 2;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", bus.busy_o); end
    if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_off: got %b expected 0", bus.rf_wr_en_o); end
  endtask

  task automatic test_back_to_back();
    cyc();
    bus.rf_wr_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b1);
      exp_q.push_back('{rd: 5'(i), data: 32'h1000_0000 + 32'(i)});
      n_checks++;
      if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.ex_ready_o); end
      cyc();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_throughput: %0d writes pending, expected 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_stall();
    bus.rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd3, 32'h11, 1'b1);
    exp_q.push_back('{rd: 5'd3, data: 32'h11});
    cyc();
    drive(1'b1, 5'd3, 32'h22, 1'b1);
    exp_q.push_back('{rd: 5'd3, data: 32'h22});
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      n_checks += 3;
      if (bus.ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b expected 0", bus.ex_ready_o); end
      if (bus.fwd_addr_o !== 5'd3 || bus.fwd_data_o !== 32'h22) begin
        n_fail++; $display("FAIL stall_fwd: got %0d/%h expected 3/22", bus.fwd_addr_o, bus.fwd_data_o);
      end
      if (bus.rf_wr_en_o !== 1'b1 || bus.rf_wr_addr_o !== 5'd3 || bus.rf_wr_data_o !== 32'h11) begin
        n_fail++; $display("FAIL stall_head: got en=%b %0d/%h expected 1 3/11",
                           bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o);
      end
      cyc();
    end
    bus.rf_wr_ready_i = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    #1;
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_drain: %0d writes pending, expected 0", exp_q.size()); end
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_filtered();
    cyc();
    bus.rf_wr_ready_i = 1'b1;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL filt_ready0: got %b expected 1", bus.ex_ready_o); end
    cyc();
    drive(1'b1, 5'd7, 32'h7777, 1'b0);
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL filt_ready1: got %b expected 1", bus.ex_ready_o); end
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL filt_wr_en[%0d]: got %b expected 0", i, bus.rf_wr_en_o); end
      if (bus.fwd_valid_o !== 1'b0) begin n_fail++; $display("FAIL filt_fwd[%0d]: got %b expected 0", i, bus.fwd_valid_o); end
      cyc();
    end
  endtask

  task automatic test_flush_and_reset();
    bus.rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd10, 32'hA0A0, 1'b1);
    cyc();
    drive(1'b1, 5'd11, 32'hB1B1, 1'b1);
    cyc();
    bus.flush_i = 1'b1;
    bus.rf_wr_ready_i = 1'b1;
    drive(1'b1, 5'd9, 32'h9999, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: wr_en got %b expected 0", bus.rf_wr_en_o); end
    cyc();
    bus.flush_i = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_checks += 3;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy_o); end
    if (bus.fwd_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_fwd: got %b expected 0", bus.fwd_valid_o); end
    if (bus.ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", bus.ex_ready_o); end
    repeat (3) cyc();

    bus.rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd12, 32'hC2C2, 1'b1);
    cyc();
    drive(1'b1, 5'd13, 32'hD3D3, 1'b1);
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    n_checks++;
    if (bus.ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL arst_prefull: ready got %b expected 0", bus.ex_ready_o); end
    #2 arst_n = 1'b0;
    #1;
    n_checks += 2;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy_o); end
    if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL arst_wr_en: got %b expected 0", bus.rf_wr_en_o); end
    cyc();
    arst_n = 1'b1;
    bus.rf_wr_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_write: got %b expected 0", bus.rf_wr_en_o); end
      cyc();
    end
  endtask

`ifdef WB_PERF_CNT_EN
  task automatic test_perf_counters();
    pulse_reset();
    bus.rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd2, 32'h2222, 1'b1);
    exp_q.push_back('{rd: 5'd2, data: 32'h2222});
    cyc();
    drive(1'b1, 5'd4, 32'h4444, 1'b1);
    exp_q.push_back('{rd: 5'd4, data: 32'h4444});
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    cyc();
    cyc();
    bus.rf_wr_ready_i = 1'b1;
    cyc();
    cyc();
    bus.rf_wr_ready_i = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (perf_stall_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
    if (perf_wr_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_wr: got %0d expected 2", perf_wr_cnt); end
    cyc();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst_n   = 1'b0;
    bus.flush_i       = 1'b0;
    bus.rf_wr_ready_i = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);

    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_filtered();
    test_flush_and_reset();
`ifdef WB_PERF_CNT_EN
    test_perf_counters();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
